// File: rtl/clock_mode_ctrl.sv
// Board clock controller: 1 s prescaler, time/alarm registers and a six-mode set FSM.
// Optional snooze on alarm acknowledge is built when CLOCK_SNOOZE_EN is defined.
module clock_mode_ctrl #(
  parameter int TICK_DIV   = 25000000,
  parameter int RING_TICKS = 60
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  output logic [2:0] mode,
  output logic       tick,
  output logic [4:0] cur_h,
  output logic [5:0] cur_m,
  output logic [5:0] cur_s,
  output logic [4:0] alm_h,
  output logic [5:0] alm_m,
  output logic       blink,
  output logic       ringing
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(RING_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(TICK_DIV - 2);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_TICKS - 1);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    SET_S = 3'd3,
    ALM_H = 3'd4,
    ALM_M = 3'd5
  } mode_t;

  mode_t         state;
  mode_t         state_nxt;
  logic          mode_prev;
  logic          inc_prev;
  logic          ack_prev;
  logic          mode_edge;
  logic          inc_edge;
  logic          ack_edge;
  logic [PW-1:0] presc;
  logic [RW-1:0] ring_cnt;
  logic          time_run;
  logic          alarm_hit;
  logic          ring_set;
  logic [4:0]    nxt_h;
  logic [5:0]    nxt_m;
  logic [5:0]    nxt_s;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  // Previous samples reset high so a button held through reset yields no edge.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      ack_prev  <= 1'b1;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      ack_prev  <= alarm_ack;
    end
  end

  assign mode_edge = btn_mode & ~mode_prev;
  assign inc_edge  = btn_inc & ~inc_prev & ~mode_edge;
  assign ack_edge  = alarm_ack & ~ack_prev;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = SET_H;
      SET_H:   state_nxt = SET_M;
      SET_M:   state_nxt = SET_S;
      SET_S:   state_nxt = ALM_H;
      ALM_H:   state_nxt = ALM_M;
      ALM_M:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state <= RUN;
      blink <= 1'b0;
    end else if (mode_edge) begin
      state <= state_nxt;
      blink <= 1'b0;
    end else if (state == RUN) begin
      blink <= 1'b0;
    end else if (tick) begin
      blink <= ~blink;
    end
  end

  assign mode = state;

  // Leaving SET_S restarts the prescaler so the first running second is a full period.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (mode_edge && state == SET_S) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      tick  <= (presc == PRESC_PRE);
    end
  end

  assign time_run = tick && (state == RUN || state == ALM_H || state == ALM_M);

  always_comb begin
    nxt_h = cur_h;
    nxt_m = cur_m;
    nxt_s = cur_s;
    if (time_run) begin
      nxt_s = inc60(cur_s);
      if (cur_s == 6'd59) begin
        nxt_m = inc60(cur_m);
        if (cur_m == 6'd59) nxt_h = inc24(cur_h);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cur_h <= '0;
      cur_m <= '0;
      cur_s <= '0;
    end else if (time_run) begin
      cur_h <= nxt_h;
      cur_m <= nxt_m;
      cur_s <= nxt_s;
    end else if (inc_edge) begin
      case (state)
        SET_H:   cur_h <= inc24(cur_h);
        SET_M:   cur_m <= inc60(cur_m);
        SET_S:   cur_s <= inc60(cur_s);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      alm_h <= '0;
      alm_m <= '0;
    end else if (inc_edge) begin
      case (state)
        ALM_H:   alm_h <= inc24(alm_h);
        ALM_M:   alm_m <= inc60(alm_m);
        default: ;
      endcase
    end
  end

  // Only a tick-driven advance can match; edits never start the alarm.
  assign alarm_hit = time_run && alarm_en && (nxt_s == 6'd0) &&
                     (nxt_m == alm_m) && (nxt_h == alm_h);

`ifdef CLOCK_SNOOZE_EN
  logic       snz_armed;
  logic [4:0] snz_h;
  logic [5:0] snz_m;
  logic [4:0] tgt_h;
  logic [5:0] tgt_m;
  logic [6:0] m_sum;
  logic       snooze_hit;
  logic       enter_set;

  always_comb begin
    m_sum = {1'b0, cur_m} + 7'd5;
    tgt_h = cur_h;
    tgt_m = m_sum[5:0];
    if (m_sum >= 7'd60) begin
      tgt_m = 6'(m_sum - 7'd60);
      tgt_h = inc24(cur_h);
    end
  end

  assign snooze_hit = time_run && snz_armed && (nxt_s == 6'd0) &&
                      (nxt_m == snz_m) && (nxt_h == snz_h);
  assign enter_set  = mode_edge &&
                      (state_nxt == SET_H || state_nxt == SET_M || state_nxt == SET_S);
  assign ring_set   = alarm_hit | snooze_hit;
`else
  assign ring_set   = alarm_hit;
`endif

  // A set in the same cycle outranks an ack, so a coincident ack is ignored.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ringing  <= 1'b0;
      ring_cnt <= '0;
`ifdef CLOCK_SNOOZE_EN
      snz_armed <= 1'b0;
      snz_h     <= '0;
      snz_m     <= '0;
`endif
    end else begin
      if (!alarm_en) begin
        ringing  <= 1'b0;
        ring_cnt <= '0;
`ifdef CLOCK_SNOOZE_EN
        snz_armed <= 1'b0;
`endif
      end else if (ring_set) begin
        ringing  <= 1'b1;
        ring_cnt <= '0;
`ifdef CLOCK_SNOOZE_EN
        snz_armed <= 1'b0;
`endif
      end else if (ringing && ack_edge) begin
        ringing  <= 1'b0;
        ring_cnt <= '0;
`ifdef CLOCK_SNOOZE_EN
        snz_armed <= 1'b1;
        snz_h     <= tgt_h;
        snz_m     <= tgt_m;
`endif
      end else if (ringing && tick) begin
        if (ring_cnt == RING_LAST) begin
          ringing  <= 1'b0;
          ring_cnt <= '0;
`ifdef CLOCK_SNOOZE_EN
          snz_armed <= 1'b0;
`endif
        end else begin
          ring_cnt <= ring_cnt + RW'(1);
        end
      end
`ifdef CLOCK_SNOOZE_EN
      if (enter_set) snz_armed <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomised and directed bench for clock_mode_ctrl, checked against a seconds-of-day model.
module tb_clock_mode_ctrl;

  localparam int TD = 4;
  localparam int RT = 3;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic       alarm_ack = 1'b0;
  logic [2:0] mode;
  logic       tick;
  logic [4:0] cur_h;
  logic [5:0] cur_m;
  logic [5:0] cur_s;
  logic [4:0] alm_h;
  logic [5:0] alm_m;
  logic       blink;
  logic       ringing;

  int checks = 0;
  int failures = 0;

  int m_mode, m_phase, m_time, m_ah, m_am, m_left, m_snz_tgt;
  bit m_tick, m_blink, m_ring, m_pm, m_pi, m_pa, m_snz_on;

  clock_mode_ctrl #(.TICK_DIV(TD), .RING_TICKS(RT)) dut (
    .clk_sys(clk_sys), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack), .mode(mode), .tick(tick),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s), .alm_h(alm_h), .alm_m(alm_m),
    .blink(blink), .ringing(ringing)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [33:0] dut_vec();
    return {mode, tick, cur_h, cur_m, cur_s, alm_h, alm_m, blink, ringing};
  endfunction

  function automatic logic [33:0] model_vec();
    return {3'(m_mode), m_tick, 5'(m_time / 3600), 6'((m_time / 60) % 60),
            6'(m_time % 60), 5'(m_ah), 6'(m_am), m_blink, m_ring};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_time = 0; m_ah = 0; m_am = 0; m_left = 0;
    m_snz_tgt = 0; m_tick = 0; m_blink = 0; m_ring = 0; m_snz_on = 0;
    m_pm = 1; m_pi = 1; m_pa = 1;
  endtask

  // Clock behaviour expressed on a seconds-of-day counter and minute-of-day alarm.
  task automatic model_step(input bit bm, input bit bi, input bit aa, input bit ae);
    int old_time, md, h, mi, s, nmd;
    bit old_tick, me, ie, ak, adv, hit, snz_hit;
    old_time = m_time; old_tick = m_tick; md = m_mode;
    me = bm && !m_pm;
    ie = bi && !m_pi && !me;
    ak = aa && !m_pa;
    adv = old_tick && (md == 0 || md >= 4);
    if (adv) m_time = (m_time + 1) % 86400;
    else if (ie && md >= 1 && md <= 3) begin
      h = m_time / 3600; mi = (m_time / 60) % 60; s = m_time % 60;
      if (md == 1) h = (h + 1) % 24;
      else if (md == 2) mi = (mi + 1) % 60;
      else s = (s + 1) % 60;
      m_time = h * 3600 + mi * 60 + s;
    end
    hit = adv && (m_time % 60 == 0) && (m_time / 60 == m_ah * 60 + m_am);
    snz_hit = adv && m_snz_on && (m_time % 60 == 0) && (m_time / 60 == m_snz_tgt);
    if (ie && md == 4) m_ah = (m_ah + 1) % 24;
    if (ie && md == 5) m_am = (m_am + 1) % 60;
    if (!ae) begin
      m_ring = 0; m_snz_on = 0;
    end else if (hit || snz_hit) begin
      m_ring = 1; m_left = RT; m_snz_on = 0;
    end else if (m_ring && ak) begin
      m_ring = 0;
`ifdef CLOCK_SNOOZE_EN
      m_snz_on = 1;
      m_snz_tgt = (old_time / 60 + 5) % 1440;
`endif
    end else if (m_ring && old_tick) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_ring = 0; m_snz_on = 0; end
    end
    if (me) m_blink = 0;
    else if (md == 0) m_blink = 0;
    else if (old_tick) m_blink = !m_blink;
    if (me) begin
      nmd = (md + 1) % 6;
      m_mode = nmd;
      if (nmd >= 1 && nmd <= 3) m_snz_on = 0;
    end
    if (me && md == 3) m_phase = 0;
    else m_phase = (m_phase + 1) % TD;
    m_tick = (m_phase == TD - 1);
    m_pm = bm; m_pi = bi; m_pa = aa;
  endtask

  task automatic cycle(input bit bm, input bit bi, input bit aa);
    btn_mode = bm; btn_inc = bi; alarm_ack = aa;
    @(posedge clk_sys);
    model_step(bm, bi, aa, alarm_en);
    #1;
  endtask

  task automatic do_reset(input bit hold_mode);
    btn_mode = hold_mode; btn_inc = 0; alarm_ack = 0; alarm_en = 0;
    rst = 1;
    repeat (2) @(posedge clk_sys);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic goto_mode(input int t);
    for (int k = 0; k < 6 && m_mode != t; k++) begin
      cycle(1, 0, 0);
      cycle(0, 0, 0);
    end
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(0, 1, 0);
      cycle(0, 0, 0);
    end
  endtask

  // Sets alarm first, then freezes and sets time; leaves the FSM in ALM_H (time running).
  task automatic setup(input int h, input int m, input int s, input int ah, input int am,
                       input bit arm);
    alarm_en = 0;
    goto_mode(4); press_inc((ah - m_ah + 24) % 24);
    goto_mode(5); press_inc((am - m_am + 60) % 60);
    goto_mode(1); press_inc((h - m_time / 3600 + 24) % 24);
    goto_mode(2); press_inc((m - (m_time / 60) % 60 + 60) % 60);
    goto_mode(3); press_inc((s - m_time % 60 + 60) % 60);
    alarm_en = arm;
    goto_mode(4);
  endtask

  task automatic wait_ring(input int bound, input string name);
    int k;
    for (k = 0; k < bound && !m_ring; k++) begin
      cycle(0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL %s_wait: got=%h want=%h", name, dut_vec(), model_vec());
      end
    end
    checks++;
    if (!m_ring || ringing !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_ring: ringing=%b want=1 after %0d cycles", name, ringing, k);
    end
  endtask

  task automatic test_reset();
    rst = 1; #1;
    checks++;
    if (dut_vec() !== 34'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: got=%h want=0", dut_vec());
    end
    do_reset(0);
    for (int k = 0; k < TD; k++) begin
      checks++;
      if (tick !== (k == TD - 1)) begin
        failures++;
        $display("[TB] FAIL first_tick: cycle=%0d tick=%b", k, tick);
      end
      cycle(0, 0, 0);
    end
  endtask

  task automatic test_tick_count();
    int nt = 0;
    do_reset(0);
    for (int k = 0; k < 240; k++) begin
      cycle(0, 0, 0);
      if (tick) nt++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL tick_run: cyc=%0d got=%h want=%h", k, dut_vec(), model_vec());
      end
    end
    checks++;
    if (nt != 60) begin
      failures++;
      $display("[TB] FAIL tick_count: got=%0d want=60", nt);
    end
    checks++;
    if (cur_h !== 5'd0 || cur_m !== 6'd1 || cur_s !== 6'd0) begin
      failures++;
      $display("[TB] FAIL tick_time: got=%0d:%0d:%0d want=0:1:0", cur_h, cur_m, cur_s);
    end
  endtask

  task automatic test_set_time();
    do_reset(0);
    setup(23, 59, 59, 0, 0, 0);
    checks++;
    if (cur_h !== 5'd23 || cur_m !== 6'd59 || cur_s !== 6'd59) begin
      failures++;
      $display("[TB] FAIL set_time: got=%0d:%0d:%0d want=23:59:59", cur_h, cur_m, cur_s);
    end
    goto_mode(0);
    for (int k = 0; k < 20 && m_time == 86399; k++) cycle(0, 0, 0);
    checks++;
    if (cur_h !== 5'd0 || cur_m !== 6'd0 || cur_s !== 6'd0 || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL rollover: got=%0d:%0d:%0d want=0:0:0", cur_h, cur_m, cur_s);
    end
  endtask

  task automatic test_button_reset();
    do_reset(1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    checks++;
    if (mode !== 3'd0) begin
      failures++;
      $display("[TB] FAIL held_btn: mode=%0d want=0", mode);
    end
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    checks++;
    if (mode !== 3'd1 || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL single_edge: mode=%0d want=1", mode);
    end
  endtask

  task automatic test_coincident();
    int h_before;
    cycle(0, 0, 0);
    h_before = m_time / 3600;
    cycle(1, 1, 0);
    checks++;
    if (mode !== 3'd2 || cur_h !== 5'(h_before)) begin
      failures++;
      $display("[TB] FAIL coincident: mode=%0d h=%0d want mode=2 h=%0d", mode, cur_h, h_before);
    end
    cycle(0, 0, 0);
  endtask

  task automatic test_alarm_timeout();
    int nt = 0;
    do_reset(0);
    setup(0, 0, 59, 0, 1, 1);
    wait_ring(40, "alarm");
    checks++;
    if (cur_h !== 5'd0 || cur_m !== 6'd1 || cur_s !== 6'd0) begin
      failures++;
      $display("[TB] FAIL alarm_time: got=%0d:%0d:%0d want=0:1:0", cur_h, cur_m, cur_s);
    end
    for (int k = 0; k < 100 && m_ring; k++) begin
      cycle(0, 0, 0);
      if (ringing && tick) nt++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL ring_hold: got=%h want=%h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (nt != RT || ringing !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ring_timeout: ticks=%0d ringing=%b want ticks=%0d ringing=0",
               nt, ringing, RT);
    end
  endtask

  task automatic test_alarm_ack();
    bit seen = 0;
    setup(0, 0, 59, 0, 1, 1);
    wait_ring(40, "ack");
    cycle(0, 0, 1);
    checks++;
    if (ringing !== 1'b0 || dut_vec() !== model_vec()) begin
      failures++;
      $display("[TB] FAIL ack_clear: ringing=%b want=0", ringing);
    end
    cycle(0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      cycle(0, 0, 0);
      if (ringing) seen = 1;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL after_ack: cyc=%0d got=%h want=%h", k, dut_vec(), model_vec());
      end
    end
    checks++;
`ifdef CLOCK_SNOOZE_EN
    if (!seen) begin
      failures++;
      $display("[TB] FAIL snooze_rering: rang=%b want=1", seen);
    end
`else
    if (seen) begin
      failures++;
      $display("[TB] FAIL ack_only: rang=%b want=0", seen);
    end
`endif
  endtask

`ifdef CLOCK_SNOOZE_EN
  task automatic test_snooze();
    do_reset(0);
    setup(23, 57, 59, 23, 58, 1);
    wait_ring(40, "snz");
    checks++;
    if (cur_h !== 5'd23 || cur_m !== 6'd58 || cur_s !== 6'd0) begin
      failures++;
      $display("[TB] FAIL snz_first: got=%0d:%0d:%0d want=23:58:0", cur_h, cur_m, cur_s);
    end
    cycle(0, 0, 1);
    checks++;
    if (ringing !== 1'b0) begin
      failures++;
      $display("[TB] FAIL snz_ack: ringing=%b want=0", ringing);
    end
    cycle(0, 0, 0);
    wait_ring(2000, "snz_again");
    checks++;
    if (cur_h !== 5'd0 || cur_m !== 6'd3 || cur_s !== 6'd0) begin
      failures++;
      $display("[TB] FAIL snz_target: got=%0d:%0d:%0d want=0:3:0", cur_h, cur_m, cur_s);
    end
  endtask
`endif

  task automatic test_reset_mid_ring();
    bit seen = 0;
    do_reset(0);
    setup(0, 0, 59, 0, 1, 1);
    wait_ring(40, "midring");
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    setup(0, 1, 59, 0, 2, 1);
    wait_ring(40, "midring2");
    #2;
    rst = 1;
    #1;
    checks++;
    if (dut_vec() !== 34'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got=%h want=0", dut_vec());
    end
    repeat (2) @(posedge clk_sys);
    #1;
    rst = 0;
    model_reset();
    alarm_en = 1;
    for (int k = 0; k < 1500; k++) begin
      cycle(0, 0, 0);
      if (ringing) seen = 1;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL post_reset: cyc=%0d got=%h want=%h", k, dut_vec(), model_vec());
      end
    end
    checks++;
    if (seen) begin
      failures++;
      $display("[TB] FAIL no_rering: rang=%b want=0", seen);
    end
  endtask

  task automatic test_random();
    bit bm, bi, aa;
    do_reset(0);
    setup(0, 0, 40, 0, 1, 1);
    for (int k = 0; k < 2000; k++) begin
      bm = ($urandom_range(0, 7) == 0) ? ~btn_mode : btn_mode;
      bi = ($urandom_range(0, 2) == 0) ? ~btn_inc : btn_inc;
      aa = ($urandom_range(0, 3) == 0) ? ~alarm_ack : alarm_ack;
      alarm_en = ($urandom_range(0, 19) != 0);
      cycle(bm, bi, aa);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("[TB] FAIL random: cyc=%0d got=%h want=%h", k, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tick_count();
    test_set_time();
    test_button_reset();
    test_coincident();
    test_alarm_timeout();
    test_alarm_ack();
`ifdef CLOCK_SNOOZE_EN
    test_snooze();
`endif
    test_reset_mid_ring();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
